// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the traffic-light input conditioning and timer
// blocks.
//   cnt_width(n)       : bits needed to hold a count 0 .. n-1 (never below 1)
//   DB_CYCLES_DEFAULT  : default number of qualifying ticks for debounce
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package tl_pkg;

    localparam int DB_CYCLES_DEFAULT = 1000;

    // A counter that runs 0 .. n-1 needs clog2(n) bits. n = 1 would give
    // zero bits, which is not a legal vector, so clamp to one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : tl_pkg

// File: rtl/sync_debounce_ch.sv
// ---------------------------------------------------------------------------
// sync_debounce_ch
// One input channel: NSYNC-flop synchroniser, debounce counter, debounced
// level and one-clock rise/fall strobes.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   tick   in   debounce count enable
//   in     in   raw asynchronous input
//   level  out  debounced level (registered)
//   rise   out  one-clock strobe on accepted 0->1 (registered)
//   fall   out  one-clock strobe on accepted 1->0 (registered)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_debounce_ch
    import tl_pkg::*;
#(
    parameter int   NSYNC     = 2,
    parameter int   DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    generate
        if (NSYNC < 2) begin : g_bad_nsync
            $error("sync_debounce_ch: NSYNC must be >= 2");
        end
        if (DB_CYCLES < 1) begin : g_bad_db
            $error("sync_debounce_ch: DB_CYCLES must be >= 1");
        end
    endgenerate

    logic [NSYNC-1:0] r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    logic w_s;
    logic w_diff;
    logic w_accept;

    assign w_s      = r_sync[NSYNC-1];
    assign w_diff   = (w_s != r_level);
    // Acceptance needs the last of DB_CYCLES consecutive mismatched ticks.
    assign w_accept = w_diff && tick && (r_cnt == CNT_LAST);

    // Synchroniser chain: bit 0 samples the raw input, the top bit is the
    // only one the debounce logic is allowed to look at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {NSYNC{RST_VAL}};
        end else begin
            r_sync <= {r_sync[NSYNC-2:0], in};
        end
    end

    // Counter clears whenever the synchronised input agrees with the stored
    // level, so any bounce back restarts qualification from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!w_diff || w_accept) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Level and strobes update together, so the strobe lands on the first
    // cycle the new level is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= RST_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_accept) begin
                r_level <= w_s;
                r_rise  <= w_s;
                r_fall  <= ~w_s;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule : sync_debounce_ch

// File: rtl/sync_debounce.sv
// ---------------------------------------------------------------------------
// sync_debounce
// Multi-channel input conditioner for pushbuttons and sensors. Each channel
// is synchronised, debounced and given registered rise/fall strobes;
// channels are fully independent.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   tick   in   debounce count enable shared by all channels
//   in     in   [WIDTH] raw asynchronous inputs
//   level  out  [WIDTH] debounced levels
//   rise   out  [WIDTH] one-clock 0->1 strobes
//   fall   out  [WIDTH] one-clock 1->0 strobes
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_debounce
    import tl_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               NSYNC     = 2,
    parameter int               DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            sync_debounce_ch #(
                .NSYNC     (NSYNC),
                .DB_CYCLES (DB_CYCLES),
                .RST_VAL   (RST_VAL[gi])
            ) u_ch (
                .clk   (clk),
                .rst_n (rst_n),
                .tick  (tick),
                .in    (in[gi]),
                .level (level[gi]),
                .rise  (rise[gi]),
                .fall  (fall[gi])
            );
        end
    endgenerate

endmodule : sync_debounce

// File: tb/tb_sync_debounce.sv
`timescale 1ns/1ps
module tb_sync_debounce;

    localparam int               WIDTH     = 4;
    localparam int               NSYNC     = 2;
    localparam int               DB_CYCLES = 4;
    localparam logic [WIDTH-1:0] RST_VAL   = 4'b0101;

    logic             clk;
    logic             rst_n;
    logic             tick;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    int n_checks = 0;
    int n_fail   = 0;

    sync_debounce #(
        .WIDTH     (WIDTH),
        .NSYNC     (NSYNC),
        .DB_CYCLES (DB_CYCLES),
        .RST_VAL   (RST_VAL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .in    (in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    // The synchronised view of the input is simply the raw input as sampled
    // NSYNC edges earlier (a delay line). A channel accepts a new value once
    // DB_CYCLES ticks have been seen while that delayed view continuously
    // disagreed with the accepted level.
    logic [WIDTH-1:0] m_delay [NSYNC];
    int               m_ticks [WIDTH];
    logic [WIDTH-1:0] m_level, m_rise, m_fall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSYNC; k++) m_delay[k] = RST_VAL;
            for (int c = 0; c < WIDTH; c++) m_ticks[c] = 0;
            m_level = RST_VAL;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            logic [WIDTH-1:0] seen;
            seen   = m_delay[NSYNC-1];
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < WIDTH; c++) begin
                if (seen[c] == m_level[c]) begin
                    m_ticks[c] = 0;
                end else if (tick) begin
                    m_ticks[c] = m_ticks[c] + 1;
                    if (m_ticks[c] == DB_CYCLES) begin
                        m_level[c] = seen[c];
                        if (seen[c]) m_rise[c] = 1'b1;
                        else         m_fall[c] = 1'b1;
                        m_ticks[c] = 0;
                    end
                end
            end
            for (int k = NSYNC - 1; k > 0; k--) m_delay[k] = m_delay[k-1];
            m_delay[0] = in;
        end
    end

    // Every-cycle comparison, 1 ns after the active edge.
    always @(posedge clk) begin
        #1;
        n_checks++;
        if ({level, rise, fall} !== {m_level, m_rise, m_fall}) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t level=%b rise=%b fall=%b required level=%b rise=%b fall=%b",
                     $time, level, rise, fall, m_level, m_rise, m_fall);
        end
        if ((rise & fall) != '0) begin
            n_fail++;
            $display("FAIL rise_fall_exclusive t=%0t rise=%b fall=%b", $time, rise, fall);
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end else begin
            $display("ok   %s t=%0t value=%b", name, $time, act);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        tick  = 1'b1;
        in    = 4'b1010;

        // Reset value held throughout reset.
        edges(3);
        check("reset_level", level, 4'b0101);
        check("reset_rise",  rise,  4'b0000);
        check("reset_fall",  fall,  4'b0000);
        rst_n = 1'b1;
        edges(5);
        check("post_reset_hold", level, 4'b0101);
        edges(1);
        check("post_reset_level", level, 4'b1010);
        check("post_reset_rise",  rise,  4'b1010);
        check("post_reset_fall",  fall,  4'b0101);
        edges(1);
        check("post_reset_strobe_clear", rise | fall, 4'b0000);

        // Clean step on channel 0.
        in[0] = 1'b1;
        edges(5);
        check("step_before", level, 4'b1010);
        edges(1);
        check("step_level", level, 4'b1011);
        check("step_rise",  rise,  4'b0001);
        check("step_fall",  fall,  4'b0000);

        // Glitch on channel 2: three clocks high is not enough.
        in[2] = 1'b1;
        edges(3);
        in[2] = 1'b0;
        edges(10);
        check("glitch_reject", level, 4'b1011);

        // Pulse long enough to qualify both edges.
        in[2] = 1'b1;
        edges(6);
        check("pulse_rise", level, 4'b1111);
        in[2] = 1'b0;
        edges(6);
        check("pulse_fall", level, 4'b1011);

        // Bounce 1,0,1 at two-clock spacing, then hold high.
        in[2] = 1'b1; edges(2);
        in[2] = 1'b0; edges(2);
        in[2] = 1'b1;
        edges(5);
        check("bounce_before", level, 4'b1011);
        edges(1);
        check("bounce_level", level, 4'b1111);
        check("bounce_rise",  rise,  4'b0100);

        // Tick every third clock: qualifying ticks at edges 4,7,10,13.
        in[2] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick = (k % 3 == 0);
            edges(1);
            if (k == 11) check("tick_gate_before", level, 4'b1111);
            if (k == 12) check("tick_gate_level",  level, 4'b1011);
        end

        // No ticks at all: mismatch never qualifies.
        tick  = 1'b0;
        in[2] = 1'b1;
        edges(20);
        check("tick_zero_hold", level, 4'b1011);
        tick = 1'b1;
        edges(8);

        // Reset after two of four ticks on channel 3.
        in[3] = 1'b0;
        in[2] = 1'b0;
        edges(2);
        in[2] = 1'b0;
        edges(2);
        rst_n = 1'b0;
        edges(2);
        check("midrst_level", level, 4'b0101);
        check("midrst_strobe", rise | fall, 4'b0000);
        rst_n = 1'b1;
        edges(5);
        check("midrst_requal_before", level, 4'b0101);
        edges(1);
        check("midrst_requal_level", level, 4'b0011);
        check("midrst_requal_rise",  rise,  4'b0010);
        check("midrst_requal_fall",  fall,  4'b0100);

        // Randomised traffic: slow random toggles, random tick, rare resets.
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < WIDTH; c++)
                if ($urandom_range(11) == 0) in[c] = ~in[c];
            tick = ($urandom_range(3) != 0);
            if ($urandom_range(599) == 0) rst_n = 1'b0;
            else                         rst_n = 1'b1;
            edges(1);
        end
        rst_n = 1'b1;
        edges(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_debounce
